// File: rtl/accel_disp_filter.sv
// accel_disp_filter: boxcar moving average feeding the display PIO; define ACCEL_DISP_DEADBAND_EN to suppress small output changes
module accel_disp_filter #(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 3,
    parameter int DEADBAND   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic              primed
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = DATA_W + LOG2_DEPTH;
    typedef enum logic {FILL, RUN} state_t;
    state_t                state;
    logic [DATA_W-1:0]     win [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH:0]   count;
    logic signed [SW-1:0]  sum, sum_next;
    logic [DATA_W-1:0]     avg;
    logic                  last, pass;
    if (LOG2_DEPTH < 1 || LOG2_DEPTH > 6 || DEADBAND < 0) begin : g_bad_param
        $error("accel_disp_filter: illegal parameter value");
    end
    assign sum_next = sum + {{LOG2_DEPTH{in_data[DATA_W-1]}}, in_data}
                          - {{LOG2_DEPTH{win[wr_ptr][DATA_W-1]}}, win[wr_ptr]};
    assign avg      = sum_next[SW-1:LOG2_DEPTH];
    assign last     = count == (LOG2_DEPTH+1)'(DEPTH - 1);
    assign primed   = state == RUN;
`ifdef ACCEL_DISP_DEADBAND_EN
    logic signed [DATA_W:0] diff;
    logic [DATA_W:0]        mag;
    assign diff = $signed({avg[DATA_W-1], avg}) - $signed({out_port[DATA_W-1], out_port});
    assign mag  = diff[DATA_W] ? -diff : diff;
    assign pass = mag >= (DATA_W+1)'(DEADBAND);
`else
    assign pass = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum       <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            state     <= FILL;
            out_valid <= 1'b0;
            if (reset) out_port <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                win[wr_ptr] <= in_data;
                sum         <= sum_next;
                wr_ptr      <= wr_ptr + 1'b1;
                if (state == FILL) count <= count + 1'b1;
                if (state == FILL && last) state <= RUN;
                if (state == FILL ? last : pass) begin
                    out_port  <= avg;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_accel_disp_filter.sv
// tb_accel_disp_filter: directed vector table plus randomized run against a window-queue reference model
module tb_accel_disp_filter;
    logic        clk = 0, reset = 1, in_valid = 0, flush = 0;
    logic [15:0] in_data = 0, out_port;
    logic        out_valid, primed;
    int          total = 0, bad = 0;

    accel_disp_filter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .out_port(out_port), .out_valid(out_valid), .primed(primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r; bit v; bit f; logic [15:0] d;
        logic [15:0] eo; bit ev; bit ep;
    } vec_t;
    vec_t tbl[$];

    int          win[$];
    int          cnt;
    logic [15:0] m_out;
    bit          m_valid, m_primed;

    task automatic add(int n, bit r, bit v, bit f, logic [15:0] d, logic [15:0] eo, bit ev, bit ep);
        for (int i = 0; i < n; i++) tbl.push_back('{r, v, f, d, eo, ev, ep});
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit v, bit f, logic [15:0] d);
        reset = r; in_valid = v; flush = f; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(bit r, bit v, bit f, logic [15:0] d);
        int s, a, x;
        bit upd;
        if (r) begin
            win = {}; cnt = 0; m_out = 0; m_valid = 0; m_primed = 0;
        end else if (f) begin
            win = {}; cnt = 0; m_valid = 0; m_primed = 0;
        end else if (v) begin
            x = $signed(d);
            win.push_back(x);
            if (win.size() > 8) void'(win.pop_front());
            cnt++;
            s = 0;
            foreach (win[i]) s += win[i];
            a = s >>> 3;
            if (!m_primed) begin
                upd = (cnt == 8);
                m_primed = upd;
            end else begin
`ifdef ACCEL_DISP_DEADBAND_EN
                x = $signed(m_out);
                upd = (a - x >= 4) || (x - a >= 4);
`else
                upd = 1;
`endif
            end
            m_valid = upd;
            if (upd) m_out = a[15:0];
        end else m_valid = 0;
    endtask

    initial begin
        logic [15:0] step_exp [8];
        logic [15:0] neg_exp [8];
        step_exp = '{16'd125, 16'd137, 16'd150, 16'd162, 16'd175, 16'd187, 16'd200, 16'd200};
        neg_exp  = '{16'h5FFF, 16'h3FFF, 16'h1FFF, 16'hFFFF, 16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h8000};
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(7, 0, 1, 0, 100, 0, 0, 0);
        add(1, 0, 1, 0, 100, 100, 1, 1);
        add(1, 0, 0, 0, 0, 100, 0, 1);
        add(1, 0, 1, 0, 200, 112, 1, 1);
        for (int i = 0; i < 7; i++) add(1, 0, 1, 0, 200, step_exp[i], 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(7, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 16'hFFFF, 16'hFFFF, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(7, 0, 1, 0, 16'hFFFD, 0, 0, 0);
        add(1, 0, 1, 0, 16'hFFFD, 16'hFFFD, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(7, 0, 1, 0, 16'h7FFF, 0, 0, 0);
        add(1, 0, 1, 0, 16'h7FFF, 16'h7FFF, 1, 1);
        for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 16'h8000, neg_exp[i], 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(7, 0, 1, 0, 100, 0, 0, 0);
        add(1, 0, 1, 0, 100, 100, 1, 1);
        add(1, 0, 1, 1, 999, 100, 0, 0);
        add(7, 0, 1, 0, 50, 100, 0, 0);
        add(1, 0, 1, 0, 50, 50, 1, 1);
        add(1, 0, 0, 1, 0, 50, 0, 0);
        add(3, 0, 1, 0, 50, 50, 0, 0);
        add(1, 1, 1, 1, 77, 0, 0, 0);
        add(7, 0, 1, 0, 100, 0, 0, 0);
        add(1, 0, 1, 0, 100, 100, 1, 1);
`ifdef ACCEL_DISP_DEADBAND_EN
        add(1, 0, 1, 0, 120, 100, 0, 1);
`else
        add(1, 0, 1, 0, 120, 102, 1, 1);
`endif
        add(1, 0, 1, 0, 140, 107, 1, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].f, tbl[i].d);
            check($sformatf("vec%0d_out", i), out_port, tbl[i].eo);
            check($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(tbl[i].ev));
            check($sformatf("vec%0d_primed", i), 16'(primed), 16'(tbl[i].ep));
        end

        model_step(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, v, f;
            logic [15:0] d;
            int k;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 3);
            d = k == 0 ? 16'($urandom) :
                k == 1 ? 16'(100 + $urandom_range(0, 12) - 6) :
                k == 2 ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) :
                         16'($urandom_range(0, 40) - 20);
            model_step(r, v, f, d);
            drive(r, v, f, d);
            check($sformatf("rnd%0d_out", n), out_port, m_out);
            check($sformatf("rnd%0d_valid", n), 16'(out_valid), 16'(m_valid));
            check($sformatf("rnd%0d_primed", n), 16'(primed), 16'(m_primed));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accel_disp_filter.md
Name: accel_disp_filter

Overview:
- Conditions raw signed accelerometer axis samples before they reach the display PIO input port.
- Sits directly upstream of the 16-bit display PIO: `out_port` wires straight to that PIO's `in_port`.
- Computes a boxcar moving average over 2^LOG2_DEPTH samples, so the Nios reads a stable value.
- Holds its output until the window is primed; reports sample and priming status.

Parameters:
- DATA_W, 16, sample and output width; two's-complement signed.
- LOG2_DEPTH, 3, log2 of the window length; window = 8 samples; legal range 1..6.
- DEADBAND, 4, minimum absolute change in LSBs needed to update the output; used only with ACCEL_DISP_DEADBAND_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  `in_data` is valid this cycle; accepted unconditionally, no backpressure.
- in_data  in  DATA_W  signed raw axis sample.
- flush  in  1  synchronous clear of the window; returns the block to FILL.
- out_port  out  DATA_W  signed averaged value; feeds the display PIO `in_port`.
- out_valid  out  1  one-cycle pulse: `out_port` updated this cycle.
- primed  out  1  high while in RUN.

Behaviour:
- Clocking and reset:
  - All state is sampled on the rising edge of `clk`.
  - `reset` is synchronous and active-high.
  - On reset: `out_port`=0, `out_valid`=0, `primed`=0, sum=0, count=0, wr_ptr=0, all buffer entries=0, state=FILL.
- Storage:
  - Circular buffer of 2^LOG2_DEPTH × DATA_W entries, indexed by wr_ptr.
  - wr_ptr wraps modulo 2^LOG2_DEPTH.
  - Running sum register, signed, DATA_W+LOG2_DEPTH bits wide, so it never overflows.
- Accept (`in_valid`=1, `flush`=0):
  - buf[wr_ptr] <= in_data.
  - sum <= sum + in_data − buf[wr_ptr]. The overwritten entry is 0 during FILL.
  - wr_ptr increments.
- Average:
  - avg = sum_next >>> LOG2_DEPTH.
  - Arithmetic shift, rounding toward −infinity; the result always fits in DATA_W bits.
- State FILL:
  - count increments per accepted sample; `out_port` holds; `out_valid`=0; `primed`=0.
  - On the accept that brings count to 2^LOG2_DEPTH:
    - go to RUN;
    - load `out_port` with avg;
    - pulse `out_valid`.
- State RUN:
  - Every accept loads `out_port` with avg and pulses `out_valid`, subject to the optional feature.
  - `primed`=1.
- Latency:
  - `out_port` and `out_valid` are registered on the same edge that accepts the sample.
  - Both are visible in the cycle after `in_valid` is high.
  - Back-to-back `in_valid` gives one result per cycle.
- `out_valid` is exactly one cycle wide. It is never asserted in a cycle with no accept on the preceding edge.
- Flush:
  - Same effect as reset, except `out_port` holds its last value.
  - `flush` takes priority over a simultaneous `in_valid`; that sample is dropped.
  - Flush in RUN or FILL returns to FILL with count=0 and `primed`=0 on the next cycle.
- Reset mid-operation has the same result as power-on reset; it dominates `flush`.
- `in_valid`=0: no state changes; `out_valid`=0.

Optional Feature:
- Macro: ACCEL_DISP_DEADBAND_EN.
- Defined:
  - In RUN, `out_port` is updated and `out_valid` pulsed only if |avg − out_port| >= DEADBAND.
  - Otherwise `out_port` holds and `out_valid`=0.
  - The sum and buffer still update on every accept.
  - The first output at the FILL→RUN transition is always loaded, regardless of DEADBAND.
  - The difference is computed at DATA_W+1 bits to avoid wrap.
- Undefined:
  - No comparator is synthesised.
  - Every RUN accept updates `out_port` and pulses `out_valid`.

Test Plan:
- Fill: reset, then 8 accepts of 100.
  - No `out_valid` during the first 7.
  - After the 8th: `out_valid` pulse, `out_port`=100, `primed`=1.
- Step response: primed at 100, then one accept of 200.
  - `out_port`=112 (sum 900>>>3).
  - After 8 accepts of 200: `out_port`=200.
- Signed rounding:
  - 7×0 then 1×−1: `out_port`=0xFFFF (−1).
  - 8×−3: `out_port`=0xFFFD.
- Extremes:
  - 8×0x7FFF: `out_port`=0x7FFF.
  - Then 8×0x8000: `out_port`=0x8000.
  - No overflow at any intermediate step.
- Flush:
  - Flush with simultaneous `in_valid` in RUN: `primed`=0, `out_port` holds; that sample is discarded.
  - 8 new accepts of 50 are then required before `out_valid`, giving `out_port`=50.
  - Reset asserted mid-fill: all outputs 0 next cycle.
- Deadband (macro defined, DEADBAND=4): primed at 100.
  - Accept of 120: avg 102, no `out_valid`, `out_port`=100.
  - Next accept of 140: avg 107, `out_valid` pulses, `out_port`=107.
  - Macro undefined: both accepts pulse, giving `out_port` 102 then 107.
